// File: rtl/chrono_wb_master_pkg.sv
// ----------------------------------------------------------------------------
// chrono_wb_master_pkg
//   Shared definitions for the stopwatch Wishbone master:
//   - BCD digit width and packed count width
//   - default display slave address (MSB set selects slave 1)
//   - bus FSM state encoding
// ----------------------------------------------------------------------------
package chrono_wb_master_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned COUNT_W = 4 * BCD_W;

    localparam logic [10:0] DISPLAY_ADDR_DEFAULT = 11'h400;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wb_state_e;

endpackage

// File: rtl/chrono_wb_master_digit.sv
// ----------------------------------------------------------------------------
// bcd_digit_counter
//   One BCD digit counting 0..MODULUS-1. Advances when inc_i is high and
//   wraps to 0, raising carry_o in the same cycle so the next digit advances
//   on the same edge.
//   Ports:
//     clk_i    - clock, rising edge
//     rst_i    - asynchronous active-high reset (digit -> 0)
//     clr_i    - synchronous clear (digit -> 0), wins over inc_i
//     inc_i    - increment request
//     digit_o  - current digit value
//     carry_o  - high when inc_i is high and the digit is at MODULUS-1
// ----------------------------------------------------------------------------
module bcd_digit_counter
    import chrono_wb_master_pkg::*;
#(
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             carry_o
);

    localparam logic [BCD_W-1:0] LAST = BCD_W'(MODULUS - 1);

    logic [BCD_W-1:0] digit_q, digit_d;

    always_comb begin
        carry_o = inc_i && (digit_q == LAST);
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = '0;
        end else if (inc_i) begin
            digit_d = carry_o ? '0 : digit_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/chrono_wb_master.sv
// ----------------------------------------------------------------------------
// chrono_wb_master
//   Centisecond stopwatch (00.00..59.99, BCD) that pushes every count change
//   to a display slave with single Wishbone write cycles.
//   Ports:
//     clk_i, rst_i          - clock (rising edge), async active-high reset
//     start_stop_i          - pulse: toggle run/pause
//     clear_i               - pulse: zero and stop (wins over start_stop_i)
//     addr_o, data_o, sel_o - Wishbone address / write data / byte select
//     data_i                - Wishbone read data (ignored)
//     cyc_o, stb_o, we_o    - Wishbone cycle / strobe / write enable
//     ack_i                 - Wishbone acknowledge
//     running_o             - high while counting
//     err_o                 - one-cycle pulse when a write times out
// ----------------------------------------------------------------------------
module chrono_wb_master
    import chrono_wb_master_pkg::*;
#(
    parameter int unsigned WB_DATA_WIDTH = 32,
    parameter int unsigned WB_ADDR_WIDTH = 11,
    parameter int unsigned GRANULARITY   = 8,
    parameter int unsigned CLK_FPGA      = 100000000,
    parameter int unsigned TICK_HZ       = 100,
    parameter logic [WB_ADDR_WIDTH-1:0] DISPLAY_ADDR = WB_ADDR_WIDTH'(DISPLAY_ADDR_DEFAULT),
    parameter int unsigned ACK_TIMEOUT   = 15
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   start_stop_i,
    input  logic                                   clear_i,
    output logic [WB_ADDR_WIDTH-1:0]               addr_o,
    output logic [WB_DATA_WIDTH-1:0]               data_o,
    input  logic [WB_DATA_WIDTH-1:0]               data_i,
    output logic                                   cyc_o,
    output logic                                   stb_o,
    output logic                                   we_o,
    output logic [WB_DATA_WIDTH/GRANULARITY-1:0]   sel_o,
    input  logic                                   ack_i,
    output logic                                   running_o,
    output logic                                   err_o
);

    localparam int unsigned PRESC_DIV = CLK_FPGA / TICK_HZ;
    localparam int unsigned PRESC_W   = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC_DIV - 1);

    localparam int unsigned SEL_W = WB_DATA_WIDTH / GRANULARITY;
    localparam logic [SEL_W-1:0] SEL_WRITE = SEL_W'(2'b11);

    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    // ---------------- prescaler and run control ----------------
    logic               running_q, running_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick;

    assign tick = running_q && (presc_q == PRESC_MAX);

    always_comb begin
        running_d = running_q;
        presc_d   = presc_q;
        if (clear_i) begin
            running_d = 1'b0;
            presc_d   = '0;
        end else begin
            if (start_stop_i) begin
                running_d = ~running_q;
            end
            if (running_q) begin
                presc_d = tick ? '0 : presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            running_q <= 1'b0;
            presc_q   <= '0;
        end else begin
            running_q <= running_d;
            presc_q   <= presc_d;
        end
    end

    // ---------------- BCD count chain ----------------
    logic [BCD_W-1:0] c_ones, c_tens, s_ones, s_tens;
    logic             carry0, carry1, carry2, carry3;
    logic [COUNT_W-1:0] count;

    bcd_digit_counter #(.MODULUS(10)) u_c_ones (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clear_i), .inc_i(tick),
        .digit_o(c_ones), .carry_o(carry0)
    );
    bcd_digit_counter #(.MODULUS(10)) u_c_tens (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clear_i), .inc_i(carry0),
        .digit_o(c_tens), .carry_o(carry1)
    );
    bcd_digit_counter #(.MODULUS(10)) u_s_ones (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clear_i), .inc_i(carry1),
        .digit_o(s_ones), .carry_o(carry2)
    );
    bcd_digit_counter #(.MODULUS(6)) u_s_tens (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clear_i), .inc_i(carry2),
        .digit_o(s_tens), .carry_o(carry3)
    );

    assign count = {s_tens, s_ones, c_tens, c_ones};

    // 59.99 simply wraps to 00.00; read data is never used.
    logic unused_sig;
    assign unused_sig = ^{data_i, carry3};

    // ---------------- Wishbone write FSM ----------------
    wb_state_e                state_q, state_d;
    logic                     pending_q, pending_d;
    logic                     bus_q, bus_d;
    logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [WB_DATA_WIDTH-1:0] data_q, data_d;
    logic                     err_q, err_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic                     count_change;

    assign count_change = tick || clear_i;

    always_comb begin
        state_d   = state_q;
        bus_d     = bus_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        data_d    = data_q;
        tmo_d     = tmo_q;
        err_d     = 1'b0;
        pending_d = pending_q || count_change;

        unique case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d = ST_WRITE;
                    bus_d   = 1'b1;
                    addr_d  = DISPLAY_ADDR;
                    sel_d   = SEL_WRITE;
                    data_d  = WB_DATA_WIDTH'(count);
                    tmo_d   = '0;
                    // A change on this very edge is newer than the snapshot.
                    pending_d = count_change;
                end
            end
            ST_WRITE: begin
                if (ack_i) begin
                    state_d = ST_IDLE;
                    bus_d   = 1'b0;
                    addr_d  = '0;
                    sel_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = ST_IDLE;
                    bus_d     = 1'b0;
                    addr_d    = '0;
                    sel_d     = '0;
                    err_d     = 1'b1;
                    pending_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b1;
            bus_q     <= 1'b0;
            addr_q    <= '0;
            sel_q     <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            bus_q     <= bus_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign cyc_o     = bus_q;
    assign stb_o     = bus_q;
    assign we_o      = bus_q;
    assign addr_o    = addr_q;
    assign sel_o     = sel_q;
    assign data_o    = data_q;
    assign err_o     = err_q;
    assign running_o = running_q;

endmodule
